key_schedule_ctrl: RTL and testbench
====================================

Name: key_schedule_ctrl

Overview:
Iterative, resource-shared AES key-schedule engine. It expands a cipher key into all Nr+1 round keys, one 32-bit word per clock, through a single shared aes_sbox instance. Results are stored in an internal round-key register file. A registered read port serves the cipher round datapath, which fetches one 128-bit round key per request.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8 for AES-128/192/256); Nr = Nk+6; W = 4*Nr+4 total words
Derived values, not overridable:
- KEYLEN = 32*Nk
- EXP_CYC = W-Nk, i.e. 40/46/52 cycles for Nk = 4/6/8

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request expansion of key; accepted only when not busy
key  in  KEYLEN  cipher key, word 0 in MSBs; sampled on the accepting edge only
busy  out  1  expansion in progress
key_ready  out  1  all W words valid; stays high until next accepted start or reset
done  out  1  one-cycle pulse coincident with key_ready rising
rd_en  in  1  round-key read request
rd_round  in  4  round index 0..Nr
rd_valid  out  1  read response strobe
rd_key  out  128  round key; word 4*r in MSBs

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, key_ready=0, done=0, rd_valid=0, rd_key=0, idx=0, rcon=8'h01. Register-file contents are don't-care.
- State machine (IDLE, EXPAND, READY):
  - IDLE/READY, start=1: on that edge write w[0..Nk-1] from key, set idx=Nk and rcon=8'h01, go to EXPAND. busy=1 and key_ready=0 from that edge.
  - EXPAND: each edge writes w[idx] = w[idx-Nk] ^ f(w[idx-1]), then idx += 1.
    - idx%Nk==0: f = SubWord(RotWord) ^ {rcon,24'h0}, then rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1b : 0).
    - Nk>6 and idx%Nk==4: f = SubWord only.
    - Otherwise f = identity.
  - SubWord uses exactly one aes_sbox instance, driven by a mux from w[idx-1] or its rotation.
  - Edge writing w[W-1]: go to READY, busy=0, key_ready=1, done=1 for the following cycle only.
- Latency: key_ready is high after exactly EXP_CYC edges following the accepting edge.
- start while busy: ignored; expansion continues undisturbed, no queueing.
- start while READY: restart. key_ready drops on the accepting edge; the old schedule is lost.
- start and rd_en in the same cycle while READY: the read completes with old data. The start is still accepted.
- Read port:
  - rd_en sampled each edge; rd_valid=1 on the next cycle, for one cycle per request.
  - Back-to-back reads are allowed, one per cycle.
  - rd_key = {w[4r], w[4r+1], w[4r+2], w[4r+3]} when key_ready=1 and r<=Nr at the sampling edge; otherwise rd_key=0 with rd_valid still pulsing.
  - rd_key holds its value between reads.
- Reset mid-EXPAND: immediate return to IDLE with reset values. Later reads return 0 until a new expansion completes.
- idx width: ceil(log2(W)) bits; never exceeds W-1; no wrap.

Test Plan:
1. Reset, then Nk=4, start with key 2b7e151628aed2a6abf7158809cf4f3c. Required: done exactly 40 cycles after accept. Read round 0 returns the key. Read round 1 returns a0fafe1788542cb123a339392a6c7605. Read round 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
2. Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4. Required: done after 52 cycles. Round 14 returns fe4890d1e6188d0b046df344706c631e.
3. Nk=4, pulse start at cycles 5 and 20 after the first accept. Required: both ignored, done still at cycle 40, results identical to scenario 1.
4. Nk=4, read during EXPAND and read rd_round=11 while READY. Required: rd_valid pulses, rd_key=0 in both cases.
5. Nk=4, assert rst asynchronously at cycle 17 of EXPAND. Required: busy=0 immediately without a clock edge. A new start with all-zero key gives round 10 b4ef5bcb3e92e21123e951cf6f8f188e after 40 cycles.
6. Nk=4, READY state: back-to-back reads of rounds 0..10 on consecutive cycles. Required: 11 consecutive rd_valid pulses with matching keys. A restart asserted on the last read cycle still returns the old round-10 key.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// Iterative AES key-schedule engine: one expanded word per clock through a
// single shared SubWord unit, with a registered 128-bit round-key read port.

module aes_sbox (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 by repeated squaring; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) dout[8*i +: 8] = sub_byte(din[8*i +: 8]);
  end

endmodule

module key_schedule_ctrl #(
  parameter  int Nk     = 4,
  localparam int KEYLEN = 32 * Nk
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEYLEN-1:0] key,
  output logic              busy,
  output logic              key_ready,
  output logic              done,
  input  logic              rd_en,
  input  logic [3:0]        rd_round,
  output logic              rd_valid,
  output logic [127:0]      rd_key
);

  localparam int NR = Nk + 6;
  localparam int W  = 4 * NR + 4;
  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t         state, state_next;
  logic [IW-1:0]  idx;
  logic [7:0]     rcon;
  logic [31:0]    w [W];

  logic           accept, last, rd_hit;
  logic [IW-1:0]  phase, idx_prev, idx_back, rd_base;
  logic [3:0]     rd_sel;
  logic [31:0]    prev_word, sub_in, sub_out, f_word, new_word;

  assign busy      = (state == EXPAND);
  assign key_ready = (state == READY);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE, READY: begin
        if (start) begin
          state_next = EXPAND;
          accept     = 1'b1;
        end
      end
      EXPAND: begin
        if (idx == IW'(W - 1)) begin
          state_next = READY;
          last       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Indices are clamped so idle-time reads never leave the register file.
  always_comb begin
    phase     = idx % IW'(Nk);
    idx_prev  = (idx == '0) ? '0 : idx - IW'(1);
    idx_back  = (idx >= IW'(Nk)) ? idx - IW'(Nk) : '0;
    prev_word = w[idx_prev];
    sub_in    = (phase == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (phase == '0)
      f_word = sub_out ^ {rcon, 24'h000000};
    else if ((Nk > 6) && (phase == IW'(4)))
      f_word = sub_out;
    else
      f_word = prev_word;
    new_word = w[idx_back] ^ f_word;
  end

  aes_sbox u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    rd_hit  = key_ready && (rd_round <= 4'(NR));
    rd_sel  = rd_hit ? rd_round : 4'd0;
    rd_base = IW'(rd_sel) << 2;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < Nk; i++) w[i] <= key[KEYLEN-1-32*i -: 32];
    end else if (busy) begin
      w[idx] <= new_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      rcon     <= 8'h01;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      state    <= state_next;
      done     <= last;
      rd_valid <= rd_en;
      if (rd_en)
        rd_key <= rd_hit ? {w[rd_base], w[rd_base + IW'(1)], w[rd_base + IW'(2)],
                            w[rd_base + IW'(3)]} : '0;
      if (accept) begin
        idx  <= IW'(Nk);
        rcon <= 8'h01;
      end else if (busy) begin
        if (!last) idx <= idx + IW'(1);
        if (phase == '0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: an AES-128 and an AES-256 instance checked
// every cycle against a word-list key-expansion model, plus directed vectors.

module tb_key_schedule_ctrl;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R0_128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] R10_ZER = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         start4 = 1'b0, rdEn4 = 1'b0;
  logic [127:0] key4 = '0;
  logic [3:0]   rdRound4 = '0;
  logic         busy4, keyReady4, done4, rdValid4;
  logic [127:0] rdKey4;

  logic         start8 = 1'b0, rdEn8 = 1'b0;
  logic [255:0] key8 = '0;
  logic [3:0]   rdRound8 = '0;
  logic         busy8, keyReady8, done8, rdValid8;
  logic [127:0] rdKey8;

  int totalChecks = 0;
  int passCount   = 0;
  bit cmpOn       = 1'b0;

  logic [7:0]   sboxT [256];
  logic [31:0]  tmpW  [60];
  logic [31:0]  mW    [2][60];
  int           mCnt  [2];
  bit           mBusy [2], mReady [2], mDone [2], mRv [2];
  logic [127:0] mRk   [2];

  key_schedule_ctrl #(.Nk(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .key(key4), .busy(busy4),
    .key_ready(keyReady4), .done(done4), .rd_en(rdEn4), .rd_round(rdRound4),
    .rd_valid(rdValid4), .rd_key(rdKey4)
  );

  key_schedule_ctrl #(.Nk(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .key(key8), .busy(busy8),
    .key_ready(keyReady8), .done(done8), .rd_en(rdEn8), .rd_round(rdRound8),
    .rd_valid(rdValid8), .rd_key(rdKey8)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    totalChecks++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Table built from the field definition: brute-force inverse, then affine map.
  task automatic buildSbox();
    logic [7:0] inv, s;
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sboxT[x] = s;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] t);
    return {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]};
  endfunction

  task automatic expandKey(input int nk, input logic [255:0] k);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 60; i++) tmpW[i] = '0;
    for (int i = 0; i < nk; i++) tmpW[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 6) + 4; i++) begin
      t = tmpW[i-1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      tmpW[i] = tmpW[i-nk] ^ t;
    end
  endtask

  // Transaction-level model: a start launches a fixed-length countdown, reads
  // are answered from the word list of the last finished expansion.
  task automatic modelStep(input int i, input logic r, input logic st, input logic [255:0] k,
                           input logic re, input logic [3:0] rr);
    int nk = (i == 0) ? 4 : 8;
    int nr = nk + 6;
    int b  = 4 * int'(rr);
    if (r) begin
      mBusy[i] = 0; mReady[i] = 0; mDone[i] = 0; mRv[i] = 0; mRk[i] = '0; mCnt[i] = 0;
      return;
    end
    mRv[i] = re;
    if (re) mRk[i] = (mReady[i] && int'(rr) <= nr) ?
                     {mW[i][b], mW[i][b+1], mW[i][b+2], mW[i][b+3]} : '0;
    mDone[i] = 0;
    if (mBusy[i]) begin
      mCnt[i]++;
      if (mCnt[i] == 4 * nr + 4 - nk) begin
        mBusy[i] = 0; mReady[i] = 1; mDone[i] = 1;
      end
    end else if (st) begin
      mBusy[i] = 1; mReady[i] = 0; mCnt[i] = 0;
      expandKey(nk, k);
      for (int j = 0; j < 60; j++) mW[i][j] = tmpW[j];
    end
  endtask

  always @(posedge clk or posedge rst) begin
    modelStep(0, rst, start4, {key4, 128'h0}, rdEn4, rdRound4);
    modelStep(1, rst, start8, key8, rdEn8, rdRound8);
  end

  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("busy4", busy4, mBusy[0]);
      checkOutput("key_ready4", keyReady4, mReady[0]);
      checkOutput("done4", done4, mDone[0]);
      checkOutput("rd_valid4", rdValid4, mRv[0]);
      checkOutput("rd_key4", rdKey4, mRk[0]);
      checkOutput("busy8", busy8, mBusy[1]);
      checkOutput("key_ready8", keyReady8, mReady[1]);
      checkOutput("done8", done8, mDone[1]);
      checkOutput("rd_valid8", rdValid8, mRv[1]);
      checkOutput("rd_key8", rdKey8, mRk[1]);
    end
  end

  task automatic applyStimulus(input int inst, input logic st, input logic [255:0] k,
                               input logic re, input logic [3:0] rr);
    if (inst == 0) begin
      start4 = st; key4 = k[255:128]; rdEn4 = re; rdRound4 = rr;
    end else begin
      start8 = st; key8 = k; rdEn8 = re; rdRound8 = rr;
    end
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0; rdEn4 = 1'b0; rdEn8 = 1'b0;
  endtask

  task automatic waitDone(input int inst, input int expCyc, input string name);
    int n = 0;
    while (n < 200 && !((inst == 0) ? done4 : done8)) begin
      applyStimulus(inst, 1'b0, '0, 1'b0, 4'd0);
      n++;
    end
    checkOutput(name, n, expCyc);
  endtask

  initial begin
    int n;
    buildSbox();

    expandKey(4, KEY128);
    checkOutput("model_r1_128", {tmpW[4], tmpW[5], tmpW[6], tmpW[7]}, R1_128);
    checkOutput("model_r10_128", {tmpW[40], tmpW[41], tmpW[42], tmpW[43]}, R10_128);
    expandKey(8, KEY256);
    checkOutput("model_r14_256", {tmpW[56], tmpW[57], tmpW[58], tmpW[59]}, R14_256);
    expandKey(4, '0);
    checkOutput("model_r10_zero", {tmpW[40], tmpW[41], tmpW[42], tmpW[43]}, R10_ZER);

    repeat (2) @(posedge clk);
    cmpOn = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_busy", busy4, 1'b0);
    checkOutput("reset_key_ready", keyReady4, 1'b0);
    checkOutput("reset_rd_key", rdKey4, '0);

    $display("[TB] scenario 1: AES-128 expansion");
    applyStimulus(0, 1'b1, KEY128, 1'b0, 4'd0);
    waitDone(0, 40, "s1_done_latency");
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd0);
    checkOutput("s1_round0", rdKey4, R0_128);
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd1);
    checkOutput("s1_round1", rdKey4, R1_128);
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd10);
    checkOutput("s1_round10", rdKey4, R10_128);

    $display("[TB] scenario 2: AES-256 expansion");
    applyStimulus(1, 1'b1, KEY256, 1'b0, 4'd0);
    waitDone(1, 52, "s2_done_latency");
    applyStimulus(1, 1'b0, '0, 1'b1, 4'd14);
    checkOutput("s2_round14", rdKey8, R14_256);

    $display("[TB] scenario 3: start while busy");
    applyStimulus(0, 1'b1, KEY128, 1'b0, 4'd0);
    n = 0;
    while (n < 200 && !done4) begin
      applyStimulus(0, (n == 5 || n == 20), '0, 1'b0, 4'd0);
      n++;
    end
    checkOutput("s3_done_latency", n, 40);
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd10);
    checkOutput("s3_round10", rdKey4, R10_128);

    $display("[TB] scenario 4: reads with no valid key");
    applyStimulus(0, 1'b1, KEY128, 1'b0, 4'd0);
    repeat (9) applyStimulus(0, 1'b0, '0, 1'b0, 4'd0);
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd2);
    checkOutput("s4_busy_rd_valid", rdValid4, 1'b1);
    checkOutput("s4_busy_rd_key", rdKey4, '0);
    waitDone(0, 30, "s4_done_latency");
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd11);
    checkOutput("s4_oob_rd_valid", rdValid4, 1'b1);
    checkOutput("s4_oob_rd_key", rdKey4, '0);

    $display("[TB] scenario 5: asynchronous reset mid-expansion");
    applyStimulus(0, 1'b1, KEY128, 1'b0, 4'd0);
    repeat (17) applyStimulus(0, 1'b0, '0, 1'b0, 4'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("s5_async_busy", busy4, 1'b0);
    checkOutput("s5_async_key_ready", keyReady4, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd10);
    checkOutput("s5_after_reset_rd_key", rdKey4, '0);
    applyStimulus(0, 1'b1, '0, 1'b0, 4'd0);
    waitDone(0, 40, "s5_done_latency");
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd10);
    checkOutput("s5_zero_round10", rdKey4, R10_ZER);

    $display("[TB] scenario 6: back-to-back reads and restart");
    applyStimulus(0, 1'b1, KEY128, 1'b0, 4'd0);
    waitDone(0, 40, "s6_done_latency");
    for (int r = 0; r < 11; r++) begin
      applyStimulus(0, (r == 10), '0, 1'b1, 4'(r));
      checkOutput("s6_rd_valid", rdValid4, 1'b1);
      if (r == 0)  checkOutput("s6_round0", rdKey4, R0_128);
      if (r == 1)  checkOutput("s6_round1", rdKey4, R1_128);
      if (r == 10) checkOutput("s6_round10_old", rdKey4, R10_128);
    end
    checkOutput("s6_restart_busy", busy4, 1'b1);
    checkOutput("s6_restart_key_ready", keyReady4, 1'b0);
    waitDone(0, 40, "s6_restart_latency");
    applyStimulus(0, 1'b0, '0, 1'b1, 4'd10);
    checkOutput("s6_new_round10", rdKey4, R10_ZER);

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
